// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer on the 27 MHz reference clock: pulses PLL reset, waits for stable lock,
// releases the core reset and services frequency-change requests with bounded retries.
module pll_reconfig_ctrl #(
  parameter logic [5:0] DEFAULT_IDSEL       = 6'd0,
  parameter logic [5:0] DEFAULT_FBDSEL      = 6'd0,
  parameter logic [5:0] DEFAULT_ODSEL       = 6'd0,
  parameter int         RESET_PULSE_CYCLES  = 16,
  parameter int         LOCK_STABLE_CYCLES  = 1024,
  parameter int         LOCK_TIMEOUT_CYCLES = 270000,
  parameter int         MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idsel,
  input  logic [5:0] req_fbdsel,
  input  logic [5:0] req_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       error,
  output logic       lock_lost
);

  localparam int RW = (RESET_PULSE_CYCLES  > 0) ? $clog2(RESET_PULSE_CYCLES + 1)  : 1;
  localparam int SW = (LOCK_STABLE_CYCLES  > 0) ? $clog2(LOCK_STABLE_CYCLES + 1)  : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 0) ? $clog2(LOCK_TIMEOUT_CYCLES + 1) : 1;
  localparam int NW = (MAX_RETRIES         > 0) ? $clog2(MAX_RETRIES + 1)         : 1;

  localparam logic [RW-1:0] RST_LAST  = RW'((RESET_PULSE_CYCLES > 1) ? RESET_PULSE_CYCLES - 1 : 0);
  // The sample that moves WAIT_LOCK into STABLE already counts as the first stable cycle.
  localparam logic [SW-1:0] STAB_LAST = SW'((LOCK_STABLE_CYCLES > 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [TW-1:0] TO_LAST   = TW'((LOCK_TIMEOUT_CYCLES > 1) ? LOCK_TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_MAX    = TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [NW-1:0] RETRY_MAX = NW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [NW-1:0] retries_q, retries_d;
  logic [5:0]    idsel_d, fbdsel_d, odsel_d;
  logic          lock_lost_d;
  logic          accept;
  logic          lock_meta, lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    to_cnt_d    = to_cnt_q;
    retries_d   = retries_q;
    idsel_d     = pll_idsel;
    fbdsel_d    = pll_fbdsel;
    odsel_d     = pll_odsel;
    lock_lost_d = lock_lost;
    accept      = req_valid && req_ready;

    // The timeout runs across WAIT_LOCK and STABLE so a flapping lock cannot stall an attempt.
    if ((state_q == ST_WAIT_LOCK || state_q == ST_STABLE) && to_cnt_q < TO_MAX)
      to_cnt_d = to_cnt_q + TW'(1);

    case (state_q)
      ST_ASSERT: begin
        if (rst_cnt_q >= RST_LAST) begin
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          if (LOCK_STABLE_CYCLES <= 1) begin
            state_d   = ST_RUN;
            retries_d = '0;
          end else begin
            state_d    = ST_STABLE;
            stab_cnt_d = '0;
          end
        end else if (to_cnt_q >= TO_LAST) begin
          if (retries_q < RETRY_MAX) begin
            retries_d = retries_q + NW'(1);
            state_d   = ST_ASSERT;
            rst_cnt_d = '0;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stab_cnt_q >= STAB_LAST) begin
          state_d   = ST_RUN;
          retries_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
      end
      ST_RUN: begin
        // A request outranks a simultaneous lock loss; the relock it triggers covers both.
        if (accept) begin
          idsel_d     = req_idsel;
          fbdsel_d    = req_fbdsel;
          odsel_d     = req_odsel;
          lock_lost_d = 1'b0;
          state_d     = ST_ASSERT;
          rst_cnt_d   = '0;
        end else if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = ST_ASSERT;
          rst_cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (accept) begin
          idsel_d     = req_idsel;
          fbdsel_d    = req_fbdsel;
          odsel_d     = req_odsel;
          lock_lost_d = 1'b0;
          retries_d   = '0;
          state_d     = ST_ASSERT;
          rst_cnt_d   = '0;
        end
      end
      default: begin
        state_d   = ST_ASSERT;
        rst_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ASSERT;
      rst_cnt_q  <= '0;
      stab_cnt_q <= '0;
      to_cnt_q   <= '0;
      retries_q  <= '0;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      req_ready  <= 1'b0;
      lock_lost  <= 1'b0;
      pll_idsel  <= DEFAULT_IDSEL;
      pll_fbdsel <= DEFAULT_FBDSEL;
      pll_odsel  <= DEFAULT_ODSEL;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      to_cnt_q   <= to_cnt_d;
      retries_q  <= retries_d;
      pll_reset  <= (state_d == ST_ASSERT) || (state_d == ST_FAULT);
      sys_rst_n  <= (state_d == ST_RUN);
      locked     <= (state_d == ST_RUN);
      error      <= (state_d == ST_FAULT);
      req_ready  <= (state_d == ST_RUN) || (state_d == ST_FAULT);
      lock_lost  <= lock_lost_d;
      pll_idsel  <= idsel_d;
      pll_fbdsel <= fbdsel_d;
      pll_odsel  <= odsel_d;
    end
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequencer for the on-chip rPLL, running on the raw board reference clock (27 MHz), not on the PLL output.
- Drives the PLL RESET input and the dynamic IDSEL/FBDSEL/ODSEL selects.
- Waits for a stable LOCK, then releases the system reset to the core.
- Services runtime frequency-change requests and recovers from lock loss, with bounded retries and a fault state.

Parameters:
- DEFAULT_IDSEL, 6'd0, select value driven from reset until the first request.
- DEFAULT_FBDSEL, 6'd0, select value driven from reset until the first request.
- DEFAULT_ODSEL, 6'd0, select value driven from reset until the first request.
- RESET_PULSE_CYCLES, 16, number of clk cycles pll_reset is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024, number of consecutive synchronized-lock-high cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 270000, number of cycles in WAIT_LOCK before an attempt fails (10 ms at 27 MHz).
- MAX_RETRIES, 3, number of failed attempts tolerated before entering FAULT.

Ports:
- clk  in  1  reference clock (board 27 MHz).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  reconfiguration request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_idsel  in  6  new IDSEL; sampled on accept.
- req_fbdsel  in  6  new FBDSEL; sampled on accept.
- req_odsel  in  6  new ODSEL; sampled on accept.
- pll_lock  in  1  PLL LOCK; asynchronous to clk.
- pll_reset  out  1  to PLL RESET (active high).
- pll_idsel  out  6  to PLL IDSEL.
- pll_fbdsel  out  6  to PLL FBDSEL.
- pll_odsel  out  6  to PLL ODSEL.
- sys_rst_n  out  1  active-low reset for logic clocked by the PLL output.
- locked  out  1  high only in RUN.
- error  out  1  high only in FAULT.
- lock_lost  out  1  sticky; set on lock loss in RUN, cleared on next accepted request.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=ASSERT, pll_reset=1, sys_rst_n=0, selects=DEFAULT_*, req_ready=0, locked=0, error=0, lock_lost=0, counters=0, retries=0.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer (lock_s). lock_s resets to 0. Only lock_s is used internally.
- Output registering: all outputs are registered. Selects are stable whenever pll_reset is low, and change only on the accept edge.
- ASSERT state:
  - pll_reset=1, sys_rst_n=0.
  - Holds for exactly RESET_PULSE_CYCLES cycles, then goes to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK state:
  - pll_reset=0.
  - lock_s=1 -> STABLE with the stable counter cleared.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES:
    - if retries<MAX_RETRIES: retries++, -> ASSERT;
    - otherwise -> FAULT.
- STABLE state:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK. The timeout counter is not cleared, so the timeout spans the whole attempt.
  - Count reaching LOCK_STABLE_CYCLES -> RUN; retries cleared.
  - If lock_s first sampled high at cycle k, sys_rst_n=1 and locked=1 are visible at cycle k+LOCK_STABLE_CYCLES.
- RUN state:
  - sys_rst_n=1, locked=1, req_ready=1.
  - Accepted request: latch req_* into pll_*sel, clear lock_lost; next cycle sys_rst_n=0, pll_reset=1, -> ASSERT.
  - lock_s=0 with no request: set lock_lost; -> ASSERT with selects unchanged.
  - Lock loss and request in the same cycle: the request wins (new selects latched), lock_lost is not set.
- FAULT state:
  - pll_reset=1, sys_rst_n=0, error=1, req_ready=1.
  - Accepted request: latch selects, clear retries and error, -> ASSERT.
  - Otherwise remain in FAULT indefinitely.
- Requests outside RUN/FAULT: req_ready=0; req_valid is ignored and not queued.
- rst_n mid-operation: immediate return to reset values. Selects revert to DEFAULT_*.
- Counter widths: $clog2(max(param)+1). Counters saturate and never wrap.

Test Plan:
Bench parameters: RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Power-up: release rst_n; raise pll_lock 10 cycles later -> pll_reset high exactly 4 cycles; sys_rst_n and locked rise 2+8=10 cycles after pll_lock rises; selects equal DEFAULT_*.
2. Glitch in STABLE: drop pll_lock for 1 cycle 5 cycles after lock_s rises -> state returns to WAIT_LOCK; sys_rst_n stays 0; release occurs 8 cycles after lock_s rises again.
3. Timeout: pll_lock held 0 -> 3 ASSERT pulses of 4 cycles each, 32-cycle waits between them, then error=1 with pll_reset held 1. A request with selects 7/2/48 -> error=0, new pulse, pll_idsel=7, pll_fbdsel=2, pll_odsel=48.
4. Reconfigure in RUN: request 7/2/48 -> req_ready sampled 1; next cycle sys_rst_n=0 and pll_reset=1; selects updated on the accept edge; re-lock -> locked=1; lock_lost=0.
5. Lock loss in RUN: drop pll_lock -> 2 cycles later state is ASSERT, lock_lost=1, selects unchanged. Same scenario with req_valid in the same cycle as lock_s falling -> new selects latched, lock_lost=0.
6. Request during WAIT_LOCK: req_valid held -> req_ready=0 and selects unchanged until RUN; the request is accepted on the first RUN cycle.
